// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: freeze/flush generation from
// taken branches, RAW hazards and data-memory wait states, plus a saturating
// stall counter and a memory time-out detector.
// Optional build macro: FORWARDING_EN (hazards reduced to load-use only).
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_valid,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [3:0]       exe_dest,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             freeze,
  output logic             flush_if,
  output logic             flush_id,
  output logic             freeze_pipe,
  output logic             branch_sel,
  output logic             mem_abort,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [7:0] MemTimeout = 8'(MEM_TIMEOUT);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic exe_match;
  logic hazard;

  assign exe_match = exe_wb_en &
                     ((exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2)));

`ifdef FORWARDING_EN
  // With forwarding only a load in EXE cannot be bypassed in time.
  logic unused_mem_writer;
  assign unused_mem_writer = ^{mem_wb_en, mem_dest};
  assign hazard = id_valid & exe_match & exe_mem_read;
`else
  logic mem_match;
  logic unused_exe_mem_read;
  assign unused_exe_mem_read = exe_mem_read;
  assign mem_match = mem_wb_en &
                     ((mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2)));
  assign hazard = id_valid & (exe_match | mem_match);
`endif

  // Branch/hazard controls shared by RUN and the ack cycle of MEMWAIT.
  logic run_freeze, run_flush_if, run_flush_id, run_branch_sel;

  always_comb begin
    run_freeze     = 1'b0;
    run_flush_if   = 1'b0;
    run_flush_id   = 1'b0;
    run_branch_sel = 1'b0;
    if (branch_taken) begin
      // Branch wins over a hazard: the dependent ID instruction is discarded.
      run_branch_sel = 1'b1;
      run_flush_if   = 1'b1;
      run_flush_id   = 1'b1;
    end else if (hazard) begin
      run_freeze   = 1'b1;
      run_flush_id = 1'b1;
    end
  end

  // Sequencer next state and combinational control outputs.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    freeze        = 1'b0;
    flush_if      = 1'b0;
    flush_id      = 1'b0;
    freeze_pipe   = 1'b0;
    branch_sel    = 1'b0;
    mem_abort     = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_req && !mem_ack) begin
          freeze      = 1'b1;
          freeze_pipe = 1'b1;
          state_d     = StMemWait;
          wait_cnt_d  = 8'd1;
        end else begin
          freeze     = run_freeze;
          flush_if   = run_flush_if;
          flush_id   = run_flush_id;
          branch_sel = run_branch_sel;
        end
      end
      StMemWait: begin
        if (mem_ack) begin
          freeze     = run_freeze;
          flush_if   = run_flush_if;
          flush_id   = run_flush_id;
          branch_sel = run_branch_sel;
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < MemTimeout) begin
          freeze      = 1'b1;
          freeze_pipe = 1'b1;
          wait_cnt_d  = wait_cnt_q + 8'd1;
        end else begin
          mem_abort     = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = StRun;
          wait_cnt_d    = 8'd0;
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = 8'd0;
      end
    endcase

    // Outputs must be quiet while reset is held, regardless of inputs.
    if (!rst) begin
      freeze      = 1'b0;
      flush_if    = 1'b0;
      flush_id    = 1'b0;
      freeze_pipe = 1'b0;
      branch_sel  = 1'b0;
      mem_abort   = 1'b0;
    end
  end

  // Saturating count of frozen cycles.
  always_comb begin
    stall_count_d = stall_count_q;
    if (freeze && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StRun;
      wait_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign timeout_err = timeout_err_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a combinational vector table in
// RUN plus hand-written memory-wait, time-out, reset and saturation sequences.
module tb_pipe_hazard_ctrl;

`ifdef FORWARDING_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [3:0]  id_src1, id_src2;
  logic        id_two_src, id_valid;
  logic        exe_wb_en, exe_mem_read;
  logic [3:0]  exe_dest;
  logic        mem_wb_en;
  logic [3:0]  mem_dest;
  logic        mem_req, mem_ack;
  logic        freeze, flush_if, flush_id, freeze_pipe, branch_sel, mem_abort, timeout_err;
  logic [15:0] stall_count;

  logic        s_freeze, s_flush_if, s_flush_id, s_freeze_pipe, s_branch_sel;
  logic        s_mem_abort, s_timeout_err;
  logic [3:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_valid(id_valid), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
    .mem_dest(mem_dest), .mem_req(mem_req), .mem_ack(mem_ack), .freeze(freeze),
    .flush_if(flush_if), .flush_id(flush_id), .freeze_pipe(freeze_pipe),
    .branch_sel(branch_sel), .mem_abort(mem_abort), .timeout_err(timeout_err),
    .stall_count(stall_count)
  );

  // Narrow counter instance used for the saturation check.
  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_valid(id_valid), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
    .mem_dest(mem_dest), .mem_req(mem_req), .mem_ack(mem_ack), .freeze(s_freeze),
    .flush_if(s_flush_if), .flush_id(s_flush_id), .freeze_pipe(s_freeze_pipe),
    .branch_sel(s_branch_sel), .mem_abort(s_mem_abort), .timeout_err(s_timeout_err),
    .stall_count(s_stall_count)
  );

  typedef struct {
    logic       br;
    logic [3:0] s1, s2;
    logic       two, valid, ewb, erd;
    logic [3:0] ed;
    logic       mwb;
    logic [3:0] md;
    logic       req, ack;
    logic [4:0] e_nf;  // {freeze, flush_if, flush_id, freeze_pipe, branch_sel}
    logic [4:0] e_fw;
  } vec_t;

  vec_t vecs[12];

  task automatic chk_ctl(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {freeze, flush_if, flush_id, freeze_pipe, branch_sel};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ctl{frz,fif,fid,fpipe,bsel} actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic idle();
    branch_taken = 1'b0; id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
    id_valid = 1'b0; exe_wb_en = 1'b0; exe_mem_read = 1'b0; exe_dest = 4'd0;
    mem_wb_en = 1'b0; mem_dest = 4'd0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  // Load in EXE writing r3 while ID reads r3: a hazard in both builds.
  task automatic load_use();
    id_valid = 1'b1; id_src1 = 4'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 4'd3;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    //               br    s1    s2   two   val   ewb   erd   ed    mwb   md    req   ack   nf        fw
    vecs[0]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0,
                 5'b00000, 5'b00000};
    vecs[1]  = '{1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0,
                 5'b10100, 5'b10100};
    vecs[2]  = '{1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0,
                 5'b10100, 5'b00000};
    vecs[3]  = '{1'b0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0,
                 5'b10100, 5'b00000};
    vecs[4]  = '{1'b1, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0,
                 5'b01101, 5'b01101};
    vecs[5]  = '{1'b0, 4'd0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0,
                 5'b00000, 5'b00000};
    vecs[6]  = '{1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b0,
                 5'b00000, 5'b00000};
    vecs[7]  = '{1'b0, 4'd1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0,
                 5'b10100, 5'b10100};
    vecs[8]  = '{1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0,
                 5'b00000, 5'b00000};
    vecs[9]  = '{1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1,
                 5'b01101, 5'b01101};
    vecs[10] = '{1'b0, 4'd3, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0,
                 5'b00000, 5'b00000};
    vecs[11] = '{1'b0, 4'd6, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 4'd6, 1'b0, 1'b0,
                 5'b10100, 5'b00000};

    // Reset holds outputs low even with a request and a branch present.
    idle();
    rst = 1'b0; mem_req = 1'b1; branch_taken = 1'b1;
    #1;
    chk_ctl("reset_ctl", 5'b00000);
    chk_bit("reset_abort", mem_abort, 1'b0);
    chk_bit("reset_terr", timeout_err, 1'b0);
    chk_cnt("reset_cnt", stall_count, 16'd0);
    @(negedge clk);
    chk_ctl("reset_ctl_held", 5'b00000);
    mem_req = 1'b0; rst = 1'b1;
    #1;
    chk_ctl("release_branch", 5'b01101);

    // Combinational vectors in RUN.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      branch_taken = vecs[i].br; id_src1 = vecs[i].s1; id_src2 = vecs[i].s2;
      id_two_src = vecs[i].two; id_valid = vecs[i].valid; exe_wb_en = vecs[i].ewb;
      exe_mem_read = vecs[i].erd; exe_dest = vecs[i].ed; mem_wb_en = vecs[i].mwb;
      mem_dest = vecs[i].md; mem_req = vecs[i].req; mem_ack = vecs[i].ack;
      #1;
      chk_ctl($sformatf("vec%0d", i), Fwd ? vecs[i].e_fw : vecs[i].e_nf);
    end

    // Load-use: one freeze cycle counted.
    do_reset();
    @(negedge clk); load_use(); #1;
    chk_ctl("loaduse_ctl", 5'b10100);
    @(negedge clk); idle(); #1;
    chk_ctl("loaduse_after", 5'b00000);
    chk_cnt("loaduse_cnt", stall_count, 16'd1);

    // Memory wait, ack on cycle 4, with a hazard pending the whole time.
    do_reset();
    @(negedge clk); mem_req = 1'b1; load_use(); #1;
    chk_ctl("memwait_c1", 5'b10010);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk); #1;
      chk_ctl($sformatf("memwait_c%0d", c), 5'b10010);
    end
    @(negedge clk); mem_ack = 1'b1; #1;
    chk_ctl("memwait_ack", 5'b10100);
    @(negedge clk); idle(); #1;
    chk_ctl("memwait_done", 5'b00000);
    chk_cnt("memwait_cnt", stall_count, 16'd4);

    // Time-out: abort on the 15th MEMWAIT cycle.
    do_reset();
    @(negedge clk); mem_req = 1'b1; #1;
    chk_ctl("tmo_req", 5'b10010);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk); #1;
      chk_ctl($sformatf("tmo_wait%0d", c), 5'b10010);
      chk_bit($sformatf("tmo_noabort%0d", c), mem_abort, 1'b0);
    end
    @(negedge clk); mem_req = 1'b0; #1;
    chk_bit("tmo_abort", mem_abort, 1'b1);
    chk_ctl("tmo_abort_ctl", 5'b00000);
    @(negedge clk); #1;
    chk_bit("tmo_pulse_end", mem_abort, 1'b0);
    chk_bit("tmo_terr", timeout_err, 1'b1);
    chk_cnt("tmo_cnt", stall_count, 16'd15);
    repeat (3) @(negedge clk);
    #1;
    chk_bit("tmo_terr_sticky", timeout_err, 1'b1);
    do_reset(); #1;
    chk_bit("tmo_terr_cleared", timeout_err, 1'b0);

    // Ack on the time-out cycle wins over the abort.
    do_reset();
    @(negedge clk); mem_req = 1'b1;
    repeat (14) @(negedge clk);
    @(negedge clk); mem_req = 1'b0; mem_ack = 1'b1; #1;
    chk_bit("tmo_ack_noabort", mem_abort, 1'b0);
    chk_ctl("tmo_ack_ctl", 5'b00000);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk_bit("tmo_ack_terr", timeout_err, 1'b0);
    chk_ctl("tmo_ack_run", 5'b00000);

    // Reset asserted mid-MEMWAIT returns to RUN at once.
    do_reset();
    @(negedge clk); mem_req = 1'b1;
    @(negedge clk); #1;
    chk_ctl("rstwait_in_wait", 5'b10010);
    #2 rst = 1'b0;
    #1;
    chk_ctl("rstwait_ctl", 5'b00000);
    chk_cnt("rstwait_cnt", stall_count, 16'd0);
    @(negedge clk); mem_req = 1'b0; rst = 1'b1; #1;
    chk_ctl("rstwait_run", 5'b00000);

    // Saturation: 20 hazard cycles into a 4-bit counter.
    do_reset();
    @(negedge clk); load_use();
    repeat (20) @(negedge clk);
    #1;
    chk_cnt("sat_cnt4", 16'(s_stall_count), 16'd15);
    chk_cnt("sat_cnt16", stall_count, 16'd20);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage ARM-subset core. Generates the freeze and flush controls for the IF stage, the IF/ID register and the later stage registers from three sources: taken branches from EXE, register read-after-write hazards between ID and the downstream writers, and a wait-state handshake with the data memory. It also counts stall cycles and flags a memory time-out. Sits beside the datapath; all outputs drive IF_stage, IF_Stage_Reg and the ID/EXE/MEM stage registers directly.

## Interface
- MEM_TIMEOUT, 15: max consecutive MEMWAIT cycles before abort (1..255)
- CNT_W, 16: stall counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- branch_taken  in  1  branch resolved taken in EXE
- id_src1, id_src2  in  4  source registers of instruction in ID
- id_two_src  in  1  ID instruction reads id_src2
- id_valid  in  1  ID holds a real instruction (not a bubble)
- exe_wb_en, exe_mem_read  in  1  EXE instruction writes a register / is a load
- exe_dest  in  4  EXE destination register
- mem_wb_en  in  1  MEM instruction writes a register
- mem_dest  in  4  MEM destination register
- mem_req, mem_ack  in  1  data-memory request from MEM / completion from memory
- freeze  out  1  holds PC and IF/ID register
- flush_if  out  1  clears IF/ID register
- flush_id  out  1  inserts bubble into ID/EXE register
- freeze_pipe  out  1  holds ID/EXE, EXE/MEM, MEM/WB registers
- branch_sel  out  1  gated Branch_taken to IF stage PC mux
- mem_abort  out  1  one-cycle pulse on time-out
- timeout_err  out  1  sticky time-out flag
- stall_count  out  CNT_W  saturating freeze-cycle counter

## Operation
- States: RUN, MEMWAIT. Reset: state RUN, wait counter 0, timeout_err 0, stall_count 0; all control outputs 0 (outputs derived combinationally from state and inputs, so reset values follow).
- hazard = id_valid & (match(exe) | match(mem)), where match(x) = x_wb_en & (x_dest==id_src1 | (id_two_src & x_dest==id_src2)); mem term and exe_mem_read qualifier per Configuration.
- RUN, priority high to low:
  - mem_req & ~mem_ack: freeze=1, freeze_pipe=1, all flushes 0, branch_sel 0; next state MEMWAIT, wait counter := 1.
  - branch_taken: branch_sel=1, flush_if=1, flush_id=1, freeze=0 (branch overrides hazard; dependent ID instruction is discarded).
  - hazard: freeze=1, flush_id=1.
  - else all 0.
- MEMWAIT:
  - mem_ack=0 and counter<MEM_TIMEOUT: freeze=freeze_pipe=1, counter increments.
  - mem_ack=1: freeze_pipe=0; outputs evaluated exactly as RUN minus the memory term (branch/hazard act this cycle); next RUN.
  - counter==MEM_TIMEOUT with mem_ack=0: mem_abort=1, timeout_err:=1, freeze=freeze_pipe=0, next RUN; ack in the same cycle takes precedence (no abort).
- stall_count increments each cycle freeze=1; saturates at all-ones; cleared only by reset.
- timeout_err cleared only by reset.

## Timing
- Control outputs are same-cycle combinational; registered state changes on clk rising edge.
- Load-use stall: exactly one freeze cycle per hazard with forwarding; branch flush: one cycle.
- Memory wait of N cycles with ack on cycle N: freeze_pipe high cycles 1..N-1, low on N.
- rst low mid-MEMWAIT: immediately RUN, outputs 0, counters 0.

## Configuration
- FORWARDING_EN defined: hazard only for load-use, match(exe) & exe_mem_read; mem term ignored.
- FORWARDING_EN undefined: hazard on any EXE or MEM writer match, no load qualifier.

## Test plan
- Reset: rst=0 with mem_req=1, branch_taken=1 -> all outputs 0, stall_count 0; release -> branch_sel=1, flush_if=flush_id=1.
- Load-use (FORWARDING_EN): exe_mem_read=1, exe_dest=3, id_src1=3 -> freeze=1, flush_id=1 one cycle, stall_count=1; with exe_mem_read=0 -> no stall.
- No forwarding: mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 -> freeze=1; same cycle branch_taken=1 -> freeze=0, flush_if=flush_id=1.
- Memory wait: mem_req=1, ack after 4 cycles -> freeze_pipe high 3 cycles then low, stall_count=4.
- Time-out: mem_req=1, no ack, MEM_TIMEOUT=15 -> mem_abort pulse on 15th cycle, timeout_err stays 1 until reset.
- Saturation: CNT_W=4, hold hazard 20 cycles -> stall_count stops at 15.
